// File: rtl/bp_gshare_btb.sv
// -----------------------------------------------------------------------------
// bp_gshare_btb
//   Fetch-stage branch predictor. It combines a set-associative branch target
//   buffer (tag + target per way, round-robin victim per set) with a gshare
//   direction predictor: a table of saturating counters indexed by PC xor
//   global history.
//
//   Prediction is purely combinational from the current state. Branch
//   resolution (at most one per cycle) trains the counter table and the BTB
//   at the clock edge. It also repairs the speculative global history register
//   when the prediction turns out to be wrong.
//
// Ports
//   clock, reset      clock; asynchronous active-low reset
//   predict_valid     fetch query valid (gates the speculative GHR shift)
//   predict_src       fetch PC
//   predict_dst       predicted next PC
//   predict_taken     predicted direction
//   predict_ghr       GHR value used for this prediction (checkpoint)
//   resolve_valid     a conditional/direct branch resolves this cycle
//   resolve_src       branch PC
//   resolve_taken     actual direction
//   resolve_dst       actual taken target
//   resolve_pred_dst  predict_dst originally handed out for this branch
//   resolve_ghr       predict_ghr originally handed out for this branch
//   resolve_right     combinational: the original prediction was correct
// -----------------------------------------------------------------------------
module bp_gshare_btb #(
  parameter int XLEN    = 32,
  parameter int SETS    = 16,
  parameter int WAYS    = 2,
  parameter int CTR_W   = 2,
  parameter int GHR_LEN = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               predict_valid,
  input  logic [XLEN-1:0]    predict_src,
  output logic [XLEN-1:0]    predict_dst,
  output logic               predict_taken,
  output logic [GHR_LEN-1:0] predict_ghr,
  input  logic               resolve_valid,
  input  logic [XLEN-1:0]    resolve_src,
  input  logic               resolve_taken,
  input  logic [XLEN-1:0]    resolve_dst,
  input  logic [XLEN-1:0]    resolve_pred_dst,
  input  logic [GHR_LEN-1:0] resolve_ghr,
  output logic               resolve_right
);

  localparam int SET_W = $clog2(SETS);
  localparam int TAG_W = XLEN - 2 - SET_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PHT_N = 2 ** GHR_LEN;

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_MIN  = '0;
  localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(WAYS - 1);
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic               valid_q [SETS][WAYS];
  logic               valid_d [SETS][WAYS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]   tag_d   [SETS][WAYS];
  logic [XLEN-1:0]    tgt_q   [SETS][WAYS];
  logic [XLEN-1:0]    tgt_d   [SETS][WAYS];
  logic [WAY_W-1:0]   vptr_q  [SETS];
  logic [WAY_W-1:0]   vptr_d  [SETS];
  logic [CTR_W-1:0]   pht_q   [PHT_N];
  logic [CTR_W-1:0]   pht_d   [PHT_N];
  logic [GHR_LEN-1:0] ghr_q;
  logic [GHR_LEN-1:0] ghr_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [SET_W-1:0]   p_set;
  logic [TAG_W-1:0]   p_tag;
  logic [GHR_LEN-1:0] p_idx;
  logic [SET_W-1:0]   r_set;
  logic [TAG_W-1:0]   r_tag;
  logic [GHR_LEN-1:0] r_idx;

  assign p_set = predict_src[2 +: SET_W];
  assign p_tag = predict_src[XLEN-1 -: TAG_W];
  assign p_idx = predict_src[2 +: GHR_LEN] ^ ghr_q;

  assign r_set = resolve_src[2 +: SET_W];
  assign r_tag = resolve_src[XLEN-1 -: TAG_W];
  assign r_idx = resolve_src[2 +: GHR_LEN] ^ resolve_ghr;

  // ---------------------------------------------------------------------------
  // Predict path (combinational, reads pre-edge state only)
  // ---------------------------------------------------------------------------
  logic            p_hit;
  logic [XLEN-1:0] p_tgt;

  always_comb begin
    p_hit = 1'b0;
    p_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[p_set][w] && (tag_q[p_set][w] == p_tag)) begin
        p_hit = 1'b1;
        p_tgt = tgt_q[p_set][w];
      end
    end
  end

  assign predict_taken = p_hit & pht_q[p_idx][CTR_W-1];
  assign predict_dst   = predict_taken ? p_tgt : (predict_src + PC_STEP);
  assign predict_ghr   = ghr_q;

  // ---------------------------------------------------------------------------
  // Resolve path: BTB lookup, free-way search, correctness
  // ---------------------------------------------------------------------------
  logic             r_hit;
  logic [WAY_W-1:0] r_way;
  logic             r_free;
  logic [WAY_W-1:0] r_free_way;
  logic [XLEN-1:0]  r_actual;

  always_comb begin
    r_hit      = 1'b0;
    r_way      = '0;
    r_free     = 1'b0;
    r_free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[r_set][w] && (tag_q[r_set][w] == r_tag)) begin
        r_hit = 1'b1;
        r_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-numbered invalid way is the one kept.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[r_set][w]) begin
        r_free     = 1'b1;
        r_free_way = WAY_W'(w);
      end
    end
  end

  assign r_actual      = resolve_taken ? resolve_dst : (resolve_src + PC_STEP);
  assign resolve_right = (resolve_pred_dst == r_actual);

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  logic [CTR_W-1:0] r_ctr;
  logic [WAY_W-1:0] alloc_way;

  assign r_ctr = pht_q[r_idx];

  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    tgt_d     = tgt_q;
    vptr_d    = vptr_q;
    pht_d     = pht_q;
    ghr_d     = ghr_q;
    alloc_way = '0;

    // Speculative history shift only for fetches the BTB recognises.
    if (predict_valid && p_hit) begin
      ghr_d = {ghr_q[GHR_LEN-2:0], predict_taken};
    end

    if (resolve_valid) begin
      if (resolve_taken) begin
        if (r_ctr != CTR_MAX) pht_d[r_idx] = r_ctr + 1'b1;
      end else begin
        if (r_ctr != CTR_MIN) pht_d[r_idx] = r_ctr - 1'b1;
      end

      if (resolve_taken) begin
        if (r_hit) begin
          tgt_d[r_set][r_way] = resolve_dst;
        end else begin
          // The round-robin pointer only moves when it actually picks a victim.
          if (r_free) begin
            alloc_way = r_free_way;
          end else begin
            alloc_way     = vptr_q[r_set];
            vptr_d[r_set] = (vptr_q[r_set] == WAY_LAST) ? '0 : (vptr_q[r_set] + 1'b1);
          end
          valid_d[r_set][alloc_way] = 1'b1;
          tag_d[r_set][alloc_way]   = r_tag;
          tgt_d[r_set][alloc_way]   = resolve_dst;
        end
      end

      // Repair from the branch's own checkpoint; overrides any same-cycle shift.
      if (!resolve_right) begin
        ghr_d = {resolve_ghr[GHR_LEN-2:0], resolve_taken};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        vptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
        end
      end
      for (int i = 0; i < PHT_N; i++) begin
        pht_q[i] <= CTR_INIT;
      end
      ghr_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      vptr_q  <= vptr_d;
      pht_q   <= pht_d;
      ghr_q   <= ghr_d;
    end
  end

endmodule

// File: tb/tb_bp_gshare_btb.sv
// -----------------------------------------------------------------------------
// tb_bp_gshare_btb
//   Scoreboard bench for bp_gshare_btb. The stimulus process computes expected
//   responses from a behavioural model and queues them. A monitor pops the
//   queues on the falling edge whenever a predict or resolve is presented.
// -----------------------------------------------------------------------------
module tb_bp_gshare_btb;

  localparam int XLEN    = 32;
  localparam int SETS    = 16;
  localparam int WAYS    = 2;
  localparam int CTR_W   = 2;
  localparam int GHR_LEN = 8;
  localparam int PHT_N   = 256;
  localparam int CMAX    = 3;
  localparam int CINIT   = 1;
  localparam int CTAKEN  = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              predict_valid = 1'b0;
  logic [XLEN-1:0]   predict_src = '0;
  logic [XLEN-1:0]   predict_dst;
  logic              predict_taken;
  logic [GHR_LEN-1:0] predict_ghr;
  logic              resolve_valid = 1'b0;
  logic [XLEN-1:0]   resolve_src = '0;
  logic              resolve_taken = 1'b0;
  logic [XLEN-1:0]   resolve_dst = '0;
  logic [XLEN-1:0]   resolve_pred_dst = '0;
  logic [GHR_LEN-1:0] resolve_ghr = '0;
  logic              resolve_right;

  bp_gshare_btb #(
    .XLEN(XLEN), .SETS(SETS), .WAYS(WAYS), .CTR_W(CTR_W), .GHR_LEN(GHR_LEN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .predict_valid(predict_valid),
    .predict_src(predict_src),
    .predict_dst(predict_dst),
    .predict_taken(predict_taken),
    .predict_ghr(predict_ghr),
    .resolve_valid(resolve_valid),
    .resolve_src(resolve_src),
    .resolve_taken(resolve_taken),
    .resolve_dst(resolve_dst),
    .resolve_pred_dst(resolve_pred_dst),
    .resolve_ghr(resolve_ghr),
    .resolve_right(resolve_right)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] dst;
    logic        taken;
    logic [7:0]  ghr;
  } pred_exp_t;

  pred_exp_t pred_q[$];
  logic      res_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  initial begin : monitor
    pred_exp_t pe;
    logic      re;
    forever begin
      @(negedge clock);
      if (predict_valid) begin
        if (pred_q.size() == 0) begin
          chk("pred_q_underflow", 64'd1, 64'd0);
        end else begin
          pe = pred_q.pop_front();
          chk("predict_dst", 64'(predict_dst), 64'(pe.dst));
          chk("predict_taken", 64'(predict_taken), 64'(pe.taken));
          chk("predict_ghr", 64'(predict_ghr), 64'(pe.ghr));
        end
      end
      if (resolve_valid) begin
        if (res_q.size() == 0) begin
          chk("res_q_underflow", 64'd1, 64'd0);
        end else begin
          re = res_q.pop_front();
          chk("resolve_right", 64'(resolve_right), 64'(re));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural reference model: entries keyed by word address, counters as
  // plain integers clamped to their range, history as an integer mod 256.
  // ---------------------------------------------------------------------------
  bit          m_valid [SETS][WAYS];
  logic [31:0] m_word  [SETS][WAYS];
  logic [31:0] m_tgt   [SETS][WAYS];
  int          m_vptr  [SETS];
  int          m_pht   [PHT_N];
  int          m_ghr;

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_vptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_word[s][w]  = '0;
        m_tgt[s][w]   = '0;
      end
    end
    for (int i = 0; i < PHT_N; i++) m_pht[i] = CINIT;
    m_ghr = 0;
  endfunction

  function automatic int m_set(input logic [31:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic int m_idx(input logic [31:0] pc, input int g);
    return int'((pc >> 2) % PHT_N) ^ g;
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    int s = m_set(pc);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_word[s][w] == (pc >> 2)) return w;
    return -1;
  endfunction

  function automatic int shift_hist(input int g, input bit t);
    return ((g * 2) + int'(t)) % PHT_N;
  endfunction

  // One clock cycle: drive inputs, queue expectations, advance the model.
  task automatic cycle(input bit pv, input logic [31:0] psrc,
                       input bit rv, input logic [31:0] rsrc, input bit rtk,
                       input logic [31:0] rdst, input logic [31:0] rpred,
                       input int rghr, input bit do_rst);
    pred_exp_t pe;
    int        pw, rw, s, new_ghr, i;
    bit        ptk, right;
    logic [31:0] actual;
    @(posedge clock);
    #1;
    predict_valid    = pv;
    predict_src      = psrc;
    resolve_valid    = rv;
    resolve_src      = rsrc;
    resolve_taken    = rtk;
    resolve_dst      = rdst;
    resolve_pred_dst = rpred;
    resolve_ghr      = 8'(rghr);
    if (do_rst) begin
      reset = 1'b0;
      m_reset();
    end

    pw  = m_find(psrc);
    ptk = (pw >= 0) && (m_pht[m_idx(psrc, m_ghr)] >= CTAKEN);
    pe.taken = ptk;
    pe.dst   = ptk ? m_tgt[m_set(psrc)][pw] : psrc + 32'd4;
    pe.ghr   = 8'(m_ghr);
    if (pv) pred_q.push_back(pe);

    actual = rtk ? rdst : rsrc + 32'd4;
    right  = (rpred == actual);
    if (rv) res_q.push_back(right);

    // State change at the coming edge (reset, if pulsed, is released first).
    new_ghr = m_ghr;
    if (pv && pw >= 0) new_ghr = shift_hist(m_ghr, ptk);
    if (rv) begin
      i = m_idx(rsrc, rghr);
      if (rtk) m_pht[i] = (m_pht[i] < CMAX) ? m_pht[i] + 1 : CMAX;
      else     m_pht[i] = (m_pht[i] > 0) ? m_pht[i] - 1 : 0;
      s  = m_set(rsrc);
      rw = m_find(rsrc);
      if (rtk) begin
        if (rw >= 0) begin
          m_tgt[s][rw] = rdst;
        end else begin
          rw = -1;
          for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) rw = w;
          if (rw < 0) begin
            rw = m_vptr[s];
            m_vptr[s] = (m_vptr[s] + 1) % WAYS;
          end
          m_valid[s][rw] = 1;
          m_word[s][rw]  = rsrc >> 2;
          m_tgt[s][rw]   = rdst;
        end
      end
      if (!right) new_ghr = shift_hist(rghr % 128, rtk);
    end
    m_ghr = new_ghr;

    if (do_rst) begin
      @(negedge clock);
      #1;
      reset = 1'b1;
    end
  endtask

  task automatic idle();
    cycle(0, '0, 0, '0, 0, '0, '0, 0, 0);
  endtask

  task automatic pred(input logic [31:0] pc);
    cycle(1, pc, 0, '0, 0, '0, '0, 0, 0);
  endtask

  task automatic res(input logic [31:0] pc, input bit tk, input logic [31:0] dst,
                     input logic [31:0] pdst, input int g);
    cycle(0, '0, 1, pc, tk, dst, pdst, g, 0);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
  endtask

  initial begin : watchdog
    #200000;
    chk("watchdog_timeout", 64'd1, 64'd0);
    summary();
    $finish;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] pool [24];

  initial begin : stim
    int g0;
    logic [31:0] rs, rd, pd, act;
    bit tk;
    m_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // After reset: miss, not taken, history zero.
    pred(32'h100);

    // Learn a taken branch, then predict it; the hit shifts history to 0x01.
    res(32'h100, 1, 32'h200, 32'h200, 0);
    pred(32'h100);
    pred(32'h104);

    // Establish GHR=0x5A via repair, then mispredict + hitting predict together.
    res(32'h300, 0, 32'h0, 32'h200, 8'h2D);
    cycle(1, 32'h100, 1, 32'h300, 0, 32'h0, 32'h200, 8'h03, 0);
    pred(32'h104);

    // Counter saturation in both directions at a fixed index.
    g0 = m_ghr;
    repeat (5) res(32'h500, 1, 32'h600, 32'h600, g0);
    repeat (4) res(32'h500, 0, 32'h0, 32'h504, g0);
    pred(32'h500);

    // Reset pulse mid-stream with both a predict and a resolve presented.
    cycle(1, 32'h100, 1, 32'h700, 0, 32'h0, 32'h704, 8'h11, 1);
    pred(32'h100);
    pred(32'h500);

    // Set-0 fill and round-robin eviction.
    res(32'h000, 1, 32'hA00, 32'hA00, m_ghr);
    res(32'h040, 1, 32'hB00, 32'hB00, m_ghr);
    res(32'h080, 1, 32'hC00, 32'hC00, m_ghr);
    pred(32'h000);
    pred(32'h040);
    pred(32'h080);
    idle();

    // Randomised traffic over a small PC pool (4 tags x 4 sets, plus wrap PCs).
    for (int i = 0; i < 22; i++)
      pool[i] = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 2)
              | 32'($urandom_range(0, 3));
    pool[22] = 32'hFFFF_FFFC;
    pool[23] = 32'hFFFF_FFFE;

    for (int n = 0; n < 800; n++) begin
      rs  = pool[$urandom_range(0, 23)];
      tk  = 1'($urandom_range(0, 1));
      rd  = $urandom_range(0, 3) == 0 ? $urandom : (32'($urandom_range(0, 255)) << 2);
      act = tk ? rd : rs + 32'd4;
      case ($urandom_range(0, 9))
        8:       pd = rs + 32'd4;
        9:       pd = rd;
        default: pd = act;
      endcase
      cycle(1'($urandom_range(0, 3) != 0), pool[$urandom_range(0, 23)],
            1'($urandom_range(0, 2) != 0), rs, tk, rd, pd,
            ($urandom_range(0, 1) != 0) ? m_ghr : int'($urandom_range(0, 255)),
            $urandom_range(0, 199) == 0);
    end

    idle();
    idle();
    chk("pred_q_drained", 64'(pred_q.size()), 64'd0);
    chk("res_q_drained", 64'(res_q.size()), 64'd0);
    summary();
    $finish;
  end

endmodule
